// File: rtl/sfu_pkg.sv
// Shared constants for the special-function-unit schedulers.
package sfu_pkg;

  localparam int unsigned LOG2_LAT = 5;

endpackage

// File: rtl/sfu_rr_arbiter.sv
// Round-robin arbiter: the search starts at the pointer, and the pointer moves past the winner on advance.
module sfu_rr_arbiter #(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] valid,
  input  logic             advance,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  win
);

  logic [ID_W-1:0] ptr_q, ptr_d;
  logic            found;
  int              idx;

  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= int'(N_REQ)) idx = idx - int'(N_REQ);
      if (!found && valid[idx]) begin
        found = 1'b1;
        win   = ID_W'(idx);
      end
    end
    grant = '0;
    if (found) grant[win] = 1'b1;
    ptr_d = ptr_q;
    if (advance && found) ptr_d = (32'(win) == N_REQ - 1) ? '0 : win + ID_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/sfu_log2_sched.sv
// Shares one pipelined log2 engine between N_REQ requesters, tagging each op with its requester ID.
module sfu_log2_sched
  import sfu_pkg::*;
#(
  parameter  int unsigned N_REQ      = 4,
  parameter  int unsigned DATA_WIDTH = 32,
  parameter  int unsigned LAT        = LOG2_LAT,
  localparam int unsigned ID_W       = $clog2(N_REQ)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            req_ready,
  output logic                        rsp_valid,
  output logic [DATA_WIDTH-1:0]       rsp_data,
  output logic [ID_W-1:0]             rsp_id,
  input  logic                        rsp_ready,
  input  logic                        drain,
  output logic                        busy,
  output logic                        err,
  output logic [DATA_WIDTH-1:0]       eng_operand,
  output logic                        eng_vld_in,
  output logic                        eng_en,
  input  logic [DATA_WIDTH-1:0]       eng_result,
  input  logic                        eng_vld_out
);

  localparam int unsigned CNT_W = $clog2(LAT + 1);

  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  win;
  logic             stall, issue, hs;

  logic [LAT-1:0]   tvld_q, tvld_d;
  logic [ID_W-1:0]  tid_q [LAT];
  logic [ID_W-1:0]  tid_d [LAT];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  sfu_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk    (clk),
    .rst    (rst),
    .valid  (req_valid),
    .advance(issue),
    .grant  (grant),
    .win    (win)
  );

  // Request and response paths are combinational; reset forces the idle values.
  always_comb begin
    stall       = eng_vld_out & ~rsp_ready & ~rst;
    eng_en      = ~stall;
    issue       = eng_en & ~drain & (|req_valid) & ~rst;
    req_ready   = issue ? grant : '0;
    eng_vld_in  = issue;
    eng_operand = req_data[int'(win)*DATA_WIDTH +: DATA_WIDTH];
    rsp_valid   = eng_vld_out & ~rst;
    rsp_data    = eng_result;
    rsp_id      = tid_q[LAT-1];
    hs          = rsp_valid & rsp_ready;
  end

  // Tag pipe mirrors the engine pipeline and freezes with it.
  always_comb begin
    tvld_d = tvld_q;
    tid_d  = tid_q;
    if (eng_en) begin
      tvld_d   = {tvld_q[LAT-2:0], issue};
      tid_d[0] = win;
      for (int s = 1; s < int'(LAT); s++) tid_d[s] = tid_q[s-1];
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (issue && !hs) begin
      if (cnt_q == CNT_W'(LAT)) err_d = 1'b1;
      else                      cnt_d = cnt_q + CNT_W'(1);
    end else if (hs && !issue) begin
      if (cnt_q == '0) err_d = 1'b1;
      else             cnt_d = cnt_q - CNT_W'(1);
    end
    if (eng_en && (eng_vld_out != tvld_q[LAT-1])) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tvld_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
      for (int s = 0; s < int'(LAT); s++) tid_q[s] <= '0;
    end else begin
      tvld_q <= tvld_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
      tid_q  <= tid_d;
    end
  end

  assign busy = (cnt_q != '0);
  assign err  = err_q;

endmodule
